i2c_target_regs: RTL and testbench
==================================

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 The block SHALL have parameter I2C_ADDR, default 7'h50, the 7-bit target address it responds to.
REQ-002 The block SHALL have parameter FILT_LEN, default 4, the number of consecutive equal clk samples needed to accept a new SCL/SDA level.
REQ-003 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port scl_in, input, 1, the raw SCL pad level.
REQ-006 The block SHALL have port sda_in, input, 1, the raw SDA pad level.
REQ-007 The block SHALL have port scl_oe, output, 1; 1 pulls SCL low.
REQ-008 The block SHALL have port sda_oe, output, 1; 1 pulls SDA low.
REQ-009 The block SHALL have port reg_addr, output, 8, the register pointer.
REQ-010 The block SHALL have port reg_wr_en, output, 1, a one-cycle write strobe.
REQ-011 The block SHALL have port reg_wr_data, output, 8, the write data, valid with reg_wr_en.
REQ-012 The block SHALL have port reg_rd_en, output, 1, a one-cycle read request.
REQ-013 The block SHALL have port reg_rd_data, input, 8, the read data, valid exactly 1 cycle after reg_rd_en.
REQ-014 The block SHALL have port busy, output, 1; it is high between an addressed START and the next STOP/START.

Function
REQ-015 scl_in and sda_in SHALL each pass a 2-FF synchronizer, then a filter that changes its output only after FILT_LEN consecutive equal samples.
REQ-016 START SHALL be detected when filtered SDA falls while filtered SCL is high; STOP when SDA rises while SCL is high.
REQ-017 Data SHALL be sampled on the filtered SCL rising edge; sda_oe SHALL change only on the cycle after the filtered SCL falling edge.
REQ-018 FSM states SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK.
REQ-019 In ADDR, 8 bits SHALL be shifted MSB first; on a match of the top 7 bits with I2C_ADDR -> ADDR_ACK (sda_oe=1 for one SCL period); on a mismatch -> IDLE with sda_oe=0.
REQ-020 After ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RD.
REQ-021 PTR SHALL load the received byte into reg_addr, then ACK (PTR_ACK) -> WR.
REQ-022 WR SHALL receive a byte, then on the 8th SCL rise pulse reg_wr_en for 1 cycle with reg_wr_data=byte at the current reg_addr, then ACK -> WR_ACK; reg_addr SHALL increment after the ACK.
REQ-023 On entry to RD, reg_rd_en SHALL pulse for 1 cycle at reg_addr; reg_rd_data SHALL be captured on the next cycle and shifted out MSB first, with sda_oe=~bit.
REQ-024 In RD_ACK, SDA SHALL be released; a master ACK (SDA low) SHALL increment reg_addr and return to RD; a NACK SHALL go to IDLE.
REQ-025 reg_addr SHALL wrap from 8'hFF to 8'h00 with no error indication.
REQ-026 START in any state SHALL abort the transfer, release sda_oe, and enter ADDR (repeated START); reg_addr SHALL be retained.
REQ-027 STOP in any state SHALL go to IDLE and release sda_oe; a partial byte SHALL be discarded with no reg_wr_en.
REQ-028 scl_oe SHALL be constant 0 (no clock stretching).
REQ-029 START and STOP SHALL never be detected in the same cycle; if SCL and SDA change in the same filtered cycle, neither SHALL be detected.

Reset
REQ-030 Reset SHALL set the FSM to IDLE, and set sda_oe=0, scl_oe=0, reg_wr_en=0, reg_rd_en=0, reg_addr=8'h00, reg_wr_data=8'h00, busy=0.
REQ-031 Reset SHALL preload the synchronizers and filters to 1 (bus idle), so that no false START occurs after reset.
REQ-032 Reset mid-transfer SHALL release SDA within 1 cycle, and no strobe SHALL occur.

Structure
REQ-033 Package i2c_target_pkg SHALL hold the FSM state enum and the constants for the ACK bit and the byte length (8).
REQ-034 Sub-module i2c_glitch_filter (sync plus FILT_LEN filter, parameterized) SHALL be instantiated once for SCL and once for SDA.

Verification
REQ-035 Write 0xA0, ptr 0x10, 0x11, 0x22 -> all ACKed; reg_wr_en twice: (0x10, 0x11) and (0x11, 0x22).
REQ-036 Write ptr 0x20, repeated START, 0xA1, read 2 bytes, ACK then NACK, model returns addr^0x5A -> bytes 0x7A, 0x7B; reg_rd_en at 0x20 and 0x21.
REQ-037 Address 0x52 write -> no ACK (sda_oe stays 0); busy=0; no strobes.
REQ-038 Ptr 0xFF, write 0x01, 0x02 -> writes at 0xFF then 0x00.
REQ-039 STOP after 5 data bits -> no reg_wr_en; FSM IDLE; sda_oe=0.
REQ-040 SDA glitches of FILT_LEN-1 cycles while SCL is high -> no START/STOP detected.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// ---------------------------------------------------------------------------
// i2c_target_pkg
// Shared types and constants for the I2C register-target block.
//   i2c_state_e : byte-level protocol FSM states
//   ACK_BIT     : SDA level that means ACK on the ninth clock
//   BYTE_LEN    : data bits per byte on the wire
//   LAST_BIT    : bit-counter value of the final bit of a byte
// ---------------------------------------------------------------------------
package i2c_target_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        ADDR_ACK = 4'd2,
        PTR      = 4'd3,
        PTR_ACK  = 4'd4,
        WR       = 4'd5,
        WR_ACK   = 4'd6,
        RD       = 4'd7,
        RD_ACK   = 4'd8
    } i2c_state_e;

    localparam logic       ACK_BIT  = 1'b0;
    localparam int         BYTE_LEN = 8;
    localparam logic [2:0] LAST_BIT = 3'(BYTE_LEN - 1);

endpackage

// File: rtl/i2c_glitch_filter.sv
// ---------------------------------------------------------------------------
// i2c_glitch_filter
// Two-flop synchronizer followed by a run-length filter: the output only
// takes a new level after FILT_LEN consecutive synchronized samples agree
// on it. Reset preloads everything to 1 so an idle bus is seen as idle.
// Ports:
//   clk     : system clock
//   reset   : synchronous active-high reset
//   pad_i   : raw asynchronous pad level
//   filt_o  : synchronized, filtered level
// ---------------------------------------------------------------------------
module i2c_glitch_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pad_i,
    output logic filt_o
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic          filt_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_q counts how many previous samples already disagreed with the
    // output; the FILT_LEN-th disagreeing sample flips the output.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/i2c_target_regs.sv
// ---------------------------------------------------------------------------
// i2c_target_regs
// I2C target exposing a byte-addressed register space. A write transfer
// sets the register pointer with its first data byte and writes every
// following byte at the auto-incrementing pointer; a read transfer returns
// bytes from the pointer, incrementing after each master ACK.
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   scl_in, sda_in       : raw bus levels
//   scl_oe, sda_oe       : open-drain pull-down enables (scl_oe is always 0)
//   reg_addr             : register pointer
//   reg_wr_en/wr_data    : one-cycle write strobe and its data
//   reg_rd_en/rd_data    : one-cycle read request, data returned next cycle
//   busy                 : addressed transfer in progress
//   dbg_state            : current protocol FSM state
// ---------------------------------------------------------------------------
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = 7'h50,
    parameter int         FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_data,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rd_data,
    output logic       busy,
    output i2c_state_e dbg_state
);

    logic scl_f;
    logic sda_f;
    logic scl_prev_q;
    logic sda_prev_q;

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk    (clk),
        .reset  (reset),
        .pad_i  (scl_in),
        .filt_o (scl_f)
    );

    i2c_glitch_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk    (clk),
        .reset  (reset),
        .pad_i  (sda_in),
        .filt_o (sda_f)
    );

    // START/STOP need SCL high in both the previous and current cycle, so an
    // SDA edge coinciding with an SCL edge is never taken as either.
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_rise  =  scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f &  scl_prev_q;
    assign start_det =  scl_f &  scl_prev_q &  sda_prev_q & ~sda_f;
    assign stop_det  =  scl_f &  scl_prev_q & ~sda_prev_q &  sda_f;

    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic [7:0] addr_q, addr_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       rd_en_q, rd_en_d;
    logic       rd_pend_q;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;

    logic [7:0] rx_byte;
    logic       last_bit;

    assign rx_byte  = {shift_q[6:0], sda_f};
    assign last_bit = (bit_cnt_q == LAST_BIT);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        rd_en_d   = 1'b0;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;

        // Read data arrives the cycle after the request; it lands long before
        // the SCL fall that starts driving it out.
        if (rd_pend_q) begin
            shift_d = reg_rd_data;
        end

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                ADDR: begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        if (rx_byte[7:1] == I2C_ADDR) begin
                            state_d = ADDR_ACK;
                            rw_d    = rx_byte[0];
                            busy_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                PTR: begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        addr_d    = rx_byte;
                        state_d   = PTR_ACK;
                    end
                end
                WR: begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        wr_en_d   = 1'b1;
                        wr_data_d = rx_byte;
                        state_d   = WR_ACK;
                    end
                end
                RD: begin
                    // The current bit is already on the bus; expose the next.
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        state_d   = RD_ACK;
                    end
                end
                ADDR_ACK: begin
                    bit_cnt_d = '0;
                    if (rw_q) begin
                        state_d = RD;
                        rd_en_d = 1'b1;
                    end else begin
                        state_d = PTR;
                    end
                end
                PTR_ACK: begin
                    bit_cnt_d = '0;
                    state_d   = WR;
                end
                WR_ACK: begin
                    bit_cnt_d = '0;
                    addr_d    = addr_q + 1'b1;
                    state_d   = WR;
                end
                RD_ACK: begin
                    bit_cnt_d = '0;
                    if (sda_f == ACK_BIT) begin
                        addr_d  = addr_q + 1'b1;
                        rd_en_d = 1'b1;
                        state_d = RD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            // SDA is only ever changed while SCL is low.
            case (state_q)
                ADDR_ACK, PTR_ACK, WR_ACK: sda_oe_d = 1'b1;
                RD:                        sda_oe_d = ~shift_q[7];
                default:                   sda_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            rd_en_q    <= 1'b0;
            rd_pend_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            rd_en_q    <= rd_en_d;
            rd_pend_q  <= rd_en_q;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
        end
    end

    assign scl_oe      = 1'b0;
    assign sda_oe      = sda_oe_q;
    assign reg_addr    = addr_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_data = wr_data_q;
    assign reg_rd_en   = rd_en_q;
    assign busy        = busy_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regs
// Directed bench for i2c_target_regs: a bit-level I2C master drives an
// open-drain bus, a small register model answers reads with addr ^ 8'h5A,
// and monitors log every write/read strobe for the per-test checks.
// ---------------------------------------------------------------------------
module tb_i2c_target_regs;
    import i2c_target_pkg::*;

    localparam int H  = 16;   // quarter-ish SCL cell length in clk cycles
    localparam int FL = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_in;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data = 8'h00;
    logic       busy;
    i2c_state_e dbg_state;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] wr_log[$];
    logic [7:0]  rd_log[$];
    logic        oe_seen = 1'b0;

    // Open-drain wired-AND bus.
    assign scl_in = scl_m & ~scl_oe;
    assign sda_in = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regs #(.I2C_ADDR(7'h50), .FILT_LEN(FL)) dut (
        .clk         (clk),
        .reset       (reset),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .scl_oe      (scl_oe),
        .sda_oe      (sda_oe),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // Register-file model: data valid the cycle after the request.
    always @(posedge clk) begin
        if (reg_rd_en) reg_rd_data <= reg_addr ^ 8'h5A;
    end

    always @(negedge clk) begin
        if (reg_wr_en) wr_log.push_back({reg_addr, reg_wr_data});
        if (reg_rd_en) rd_log.push_back(reg_addr);
        if (sda_oe)    oe_seen = 1'b1;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(H);
        scl_m = 1'b1; tick(H);
        sda_m = 1'b0; tick(H);
        scl_m = 1'b0; tick(H);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(H);
        scl_m = 1'b1; tick(H);
        sda_m = 1'b1; tick(H);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        sda_m = b; tick(H);
        scl_m = 1'b1;
        if (glitch) begin
            tick(8);
            sda_m = ~b; tick(FL - 1);
            sda_m = b;  tick(H - 8 - (FL - 1));
        end else begin
            tick(H);
        end
        scl_m = 1'b0; tick(H);
    endtask

    task automatic ack_cell(output logic ack);
        sda_m = 1'b1; tick(H);
        scl_m = 1'b1; tick(H / 2);
        ack = ~sda_in;
        tick(H / 2);
        scl_m = 1'b0; tick(H);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
        ack_cell(ack);
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; tick(H);
            scl_m = 1'b1; tick(H / 2);
            d[i] = sda_in;
            tick(H / 2);
            scl_m = 1'b0; tick(H);
        end
        sda_m = master_ack ? 1'b0 : 1'b1; tick(H);
        scl_m = 1'b1; tick(H);
        scl_m = 1'b0; tick(H);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
        exp_q.delete();
        oe_seen = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; tick(3);
        reset = 1'b0; tick(2);
        total++; if (sda_oe !== 1'b0)      begin bad++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        total++; if (scl_oe !== 1'b0)      begin bad++; $display("FAIL reset_scl_oe: got %b want 0", scl_oe); end
        total++; if (reg_wr_en !== 1'b0)   begin bad++; $display("FAIL reset_wr_en: got %b want 0", reg_wr_en); end
        total++; if (reg_rd_en !== 1'b0)   begin bad++; $display("FAIL reset_rd_en: got %b want 0", reg_rd_en); end
        total++; if (reg_addr !== 8'h00)   begin bad++; $display("FAIL reset_addr: got %h want 00", reg_addr); end
        total++; if (reg_wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data: got %h want 00", reg_wr_data); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (dbg_state !== IDLE)   begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    endtask

    task automatic test_write();
        logic a0, a1, a2, a3;
        clear_logs();
        exp_q.push_back(16'h1011);
        exp_q.push_back(16'h1122);
        bus_start();
        send_byte(8'hA0, a0);
        send_byte(8'h10, a1);
        send_byte(8'h11, a2);
        send_byte(8'h22, a3);
        total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL write_acks: got %b want 1111", {a0, a1, a2, a3}); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL write_busy_active: got %b want 1", busy); end
        bus_stop(); tick(10);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL write_state_after_stop: got %0d want %0d", dbg_state, IDLE); end
        total++; if (wr_log.size() != exp_q.size()) begin bad++; $display("FAIL write_count: got %0d want %0d", wr_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
            total++; if (wr_log[i] !== exp_q[i]) begin bad++; $display("FAIL write_entry%0d: got %h want %h", i, wr_log[i], exp_q[i]); end
        end
        total++; if (reg_addr !== 8'h12) begin bad++; $display("FAIL write_final_addr: got %h want 12", reg_addr); end
    endtask

    task automatic test_read();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        clear_logs();
        bus_start();
        send_byte(8'hA0, a0);
        send_byte(8'h20, a1);
        bus_start();
        send_byte(8'hA1, a2);
        recv_byte(1'b1, d0);
        recv_byte(1'b0, d1);
        bus_stop(); tick(10);
        total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL read_acks: got %b want 111", {a0, a1, a2}); end
        total++; if (d0 !== 8'h7A) begin bad++; $display("FAIL read_byte0: got %h want 7a", d0); end
        total++; if (d1 !== 8'h7B) begin bad++; $display("FAIL read_byte1: got %h want 7b", d1); end
        total++; if (rd_log.size() != 2) begin bad++; $display("FAIL read_req_count: got %0d want 2", rd_log.size()); end
        if (rd_log.size() == 2) begin
            total++; if (rd_log[0] !== 8'h20) begin bad++; $display("FAIL read_req0_addr: got %h want 20", rd_log[0]); end
            total++; if (rd_log[1] !== 8'h21) begin bad++; $display("FAIL read_req1_addr: got %h want 21", rd_log[1]); end
        end
        total++; if (wr_log.size() != 0) begin bad++; $display("FAIL read_no_writes: got %0d want 0", wr_log.size()); end
        total++; if (reg_addr !== 8'h21) begin bad++; $display("FAIL read_final_addr: got %h want 21", reg_addr); end
    endtask

    task automatic test_bad_addr();
        logic a0;
        clear_logs();
        bus_start();
        send_byte(8'hA4, a0);
        total++; if (a0 !== 1'b0) begin bad++; $display("FAIL badaddr_ack: got %b want 0", a0); end
        total++; if (oe_seen !== 1'b0) begin bad++; $display("FAIL badaddr_sda_oe_seen: got %b want 0", oe_seen); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL badaddr_busy: got %b want 0", busy); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL badaddr_state: got %0d want %0d", dbg_state, IDLE); end
        bus_stop(); tick(10);
        total++; if (wr_log.size() + rd_log.size() != 0) begin bad++; $display("FAIL badaddr_strobes: got %0d want 0", wr_log.size() + rd_log.size()); end
    endtask

    task automatic test_wrap();
        logic a0, a1, a2, a3;
        clear_logs();
        exp_q.push_back(16'hFF01);
        exp_q.push_back(16'h0002);
        bus_start();
        send_byte(8'hA0, a0);
        send_byte(8'hFF, a1);
        send_byte(8'h01, a2);
        send_byte(8'h02, a3);
        bus_stop(); tick(10);
        total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL wrap_acks: got %b want 1111", {a0, a1, a2, a3}); end
        total++; if (wr_log.size() != exp_q.size()) begin bad++; $display("FAIL wrap_count: got %0d want %0d", wr_log.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
            total++; if (wr_log[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_entry%0d: got %h want %h", i, wr_log[i], exp_q[i]); end
        end
        total++; if (reg_addr !== 8'h01) begin bad++; $display("FAIL wrap_final_addr: got %h want 01", reg_addr); end
    endtask

    task automatic test_partial_stop();
        logic a0, a1;
        logic [4:0] bits;
        clear_logs();
        bits = 5'b10110;
        bus_start();
        send_byte(8'hA0, a0);
        send_byte(8'h40, a1);
        for (int i = 4; i >= 0; i--) send_bit(bits[i], 1'b0);
        bus_stop(); tick(10);
        total++; if ({a0, a1} !== 2'b11) begin bad++; $display("FAIL partial_acks: got %b want 11", {a0, a1}); end
        total++; if (wr_log.size() != 0) begin bad++; $display("FAIL partial_no_write: got %0d want 0", wr_log.size()); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL partial_state: got %0d want %0d", dbg_state, IDLE); end
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL partial_sda_oe: got %b want 0", sda_oe); end
        total++; if (reg_addr !== 8'h40) begin bad++; $display("FAIL partial_addr: got %h want 40", reg_addr); end
    endtask

    task automatic test_glitch();
        logic a0, a1, a2;
        logic [7:0] b;
        clear_logs();
        // Short low pulse on an idle bus must not look like START.
        sda_m = 1'b0; tick(FL - 1);
        sda_m = 1'b1; tick(20);
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL glitch_idle_state: got %0d want %0d", dbg_state, IDLE); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle_busy: got %b want 0", busy); end
        bus_start();
        send_byte(8'hA0, a0);
        send_byte(8'h30, a1);
        b = 8'h3C;
        send_bit(b[7], 1'b1);   // false STOP attempt
        total++; if (dbg_state !== WR) begin bad++; $display("FAIL glitch_mid_state: got %0d want %0d", dbg_state, WR); end
        send_bit(b[6], 1'b0);
        send_bit(b[5], 1'b1);   // false START attempt
        for (int i = 4; i >= 0; i--) send_bit(b[i], 1'b0);
        ack_cell(a2);
        bus_stop(); tick(10);
        total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL glitch_acks: got %b want 111", {a0, a1, a2}); end
        total++; if (wr_log.size() != 1) begin bad++; $display("FAIL glitch_write_count: got %0d want 1", wr_log.size()); end
        if (wr_log.size() == 1) begin
            total++; if (wr_log[0] !== 16'h303C) begin bad++; $display("FAIL glitch_write_entry: got %h want 303c", wr_log[0]); end
        end
    endtask

    task automatic test_reset_mid();
        logic got;
        logic [7:0] b;
        clear_logs();
        b = 8'hA0;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
        sda_m = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 4 * H && !got; i++) begin
            tick(1);
            if (sda_oe) got = 1'b1;
        end
        total++; if (got !== 1'b1) begin bad++; $display("FAIL resetmid_ack_wait: sda_oe got 0 want 1 within %0d cycles", 4 * H); end
        reset = 1'b1;
        scl_m = 1'b1;
        tick(1);
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL resetmid_sda_release: got %b want 0", sda_oe); end
        tick(2);
        reset = 1'b0;
        tick(20);
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL resetmid_state: got %0d want %0d", dbg_state, IDLE); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL resetmid_busy: got %b want 0", busy); end
        total++; if (wr_log.size() + rd_log.size() != 0) begin bad++; $display("FAIL resetmid_strobes: got %0d want 0", wr_log.size() + rd_log.size()); end
        total++; if (reg_addr !== 8'h00) begin bad++; $display("FAIL resetmid_addr: got %h want 00", reg_addr); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_wrap();
        test_partial_stop();
        test_glitch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
